shot_hit_detector: RTL and testbench

- Reader/consumer side of the shot slot table. Once per frame it scans every shot slot, tests each live shot against the duck bounding box, and on a hit requests slot clearing through a req/ack handshake.
- Emits a one-cycle duck_hit pulse and keeps a saturating hit count.
- Sits between the shot slot table (writer side), the duck motion logic and the score display.

---
 rtl/shot_pkg.sv | 19 +
 rtl/box_hit_cmp.sv | 33 +++
 rtl/shot_hit_detector.sv | 130 +++++++++++++
 tb/tb_shot_hit_detector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
// rtl/shot_pkg.sv - shared constants and FSM state type for the shot slot logic
package shot_pkg;

  localparam int NUM_SHOTS    = 8;
  localparam int ADDR_W       = 3;
  localparam int SHOT_Y_SPAWN = 424;
  localparam int SHOT_Y_MIN   = -10;
  localparam int DUCK_W       = 32;
  localparam int DUCK_H       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CHECK,
    ST_KILL,
    ST_DONE
  } hit_state_e;

endpackage

// File: rtl/box_hit_cmp.sv
// rtl/box_hit_cmp.sv - combinational point-in-box test for a shot against the duck
module box_hit_cmp import shot_pkg::*; #(
  parameter int BOX_W = DUCK_W,
  parameter int BOX_H = DUCK_H
) (
  input  logic              [9:0] box_x,
  input  logic signed       [9:0] box_y,
  input  logic              [9:0] pt_x,
  input  logic signed       [9:0] pt_y,
  output logic                    hit
);

  // One bit beyond the 11-bit signed range, so a box whose left edge sits
  // near 1023 still has a right edge above its left edge.
  logic signed [11:0] bx_lo;
  logic signed [11:0] bx_hi;
  logic signed [11:0] by_lo;
  logic signed [11:0] by_hi;
  logic signed [11:0] px;
  logic signed [11:0] py;

  // x is unsigned (zero-extend), y is signed (sign-extend); bounds are inclusive
  always_comb begin
    bx_lo = $signed({2'b00, box_x});
    bx_hi = bx_lo + 12'(BOX_W - 1);
    by_lo = {{2{box_y[9]}}, box_y};
    by_hi = by_lo + 12'(BOX_H - 1);
    px    = $signed({2'b00, pt_x});
    py    = {{2{pt_y[9]}}, pt_y};
    hit   = (px >= bx_lo) && (px <= bx_hi) && (py >= by_lo) && (py <= by_hi);
  end

endmodule

// File: rtl/shot_hit_detector.sv
// rtl/shot_hit_detector.sv - per-frame shot slot scan, duck hit detection and slot kill handshake
module shot_hit_detector import shot_pkg::*; #(
  parameter int NUM_SHOTS = shot_pkg::NUM_SHOTS,
  parameter int ADDR_W    = shot_pkg::ADDR_W,
  parameter int DUCK_W    = shot_pkg::DUCK_W,
  parameter int DUCK_H    = shot_pkg::DUCK_H,
  parameter int SCORE_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic          [9:0] duck_x,
  input  logic signed   [9:0] duck_y,
  input  logic                duck_alive,
  output logic [ADDR_W-1:0]   slot_addr,
  input  logic                slot_valid,
  input  logic          [9:0] slot_x,
  input  logic signed   [9:0] slot_y,
  output logic                kill_req,
  output logic [ADDR_W-1:0]   kill_addr,
  input  logic                kill_ack,
  output logic                duck_hit,
  output logic [SCORE_W-1:0]  hit_count,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_SHOTS - 1);

  hit_state_e          state;
  hit_state_e          state_d;
  logic [ADDR_W-1:0]   slot_addr_d;
  logic [ADDR_W-1:0]   kill_addr_d;
  logic                kill_req_d;
  logic                duck_hit_d;
  logic                busy_d;
  logic [SCORE_W-1:0]  hit_count_d;
  logic                in_box;
  logic                slot_hit;

  box_hit_cmp #(
    .BOX_W (DUCK_W),
    .BOX_H (DUCK_H)
  ) u_box_hit_cmp (
    .box_x (duck_x),
    .box_y (duck_y),
    .pt_x  (slot_x),
    .pt_y  (slot_y),
    .hit   (in_box)
  );

  assign slot_hit = slot_valid & in_box;

  // State and all outputs are registered; reset clears them without a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      slot_addr <= '0;
      kill_req  <= 1'b0;
      kill_addr <= '0;
      duck_hit  <= 1'b0;
      hit_count <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      slot_addr <= slot_addr_d;
      kill_req  <= kill_req_d;
      kill_addr <= kill_addr_d;
      duck_hit  <= duck_hit_d;
      hit_count <= hit_count_d;
      busy      <= busy_d;
    end
  end

  // Next state and next output values; duck_hit is a pulse so it defaults low
  always_comb begin
    state_d     = state;
    slot_addr_d = slot_addr;
    kill_req_d  = kill_req;
    kill_addr_d = kill_addr;
    duck_hit_d  = 1'b0;
    hit_count_d = hit_count;
    busy_d      = busy;
    unique case (state)
      ST_IDLE: begin
        if (frame_tick && duck_alive) begin
          state_d     = ST_ADDR;
          slot_addr_d = '0;
          busy_d      = 1'b1;
        end
      end
      ST_ADDR: begin
        // slot read data lands one cycle after the address
        state_d = duck_alive ? ST_CHECK : ST_DONE;
      end
      ST_CHECK: begin
        if (!duck_alive) begin
          state_d = ST_DONE;
        end else if (slot_hit) begin
          state_d     = ST_KILL;
          kill_req_d  = 1'b1;
          kill_addr_d = slot_addr;
        end else if (slot_addr < LAST_SLOT) begin
          state_d     = ST_ADDR;
          slot_addr_d = slot_addr + 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_KILL: begin
        // a started kill always completes, even if the duck dies meanwhile
        if (kill_ack) begin
          state_d    = ST_DONE;
          kill_req_d = 1'b0;
          duck_hit_d = 1'b1;
          if (hit_count != '1) begin
            hit_count_d = hit_count + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shot_hit_detector.sv
// tb/tb_shot_hit_detector.sv - randomized self-checking bench for shot_hit_detector
module tb_shot_hit_detector;
  import shot_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_tick;
  logic         [9:0] duck_x;
  logic signed  [9:0] duck_y;
  logic               duck_alive;
  logic         [2:0] slot_addr;
  logic               slot_valid;
  logic         [9:0] slot_x;
  logic signed  [9:0] slot_y;
  logic               kill_req;
  logic         [2:0] kill_addr;
  logic               kill_ack;
  logic               duck_hit;
  logic         [7:0] hit_count;
  logic               busy;

  logic kill_ack_r = 1'b0;
  logic kill_ack_stray;
  int   ack_cnt = 0;
  int   ack_hold;

  int tv [8];
  int tx [8];
  int ty [8];
  int dk_x, dk_y;
  int exp_cnt;
  int last_s;
  int n_vec = 0;
  int n_bad = 0;

  assign kill_ack = kill_ack_r | kill_ack_stray;

  shot_hit_detector dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .duck_x     (duck_x),
    .duck_y     (duck_y),
    .duck_alive (duck_alive),
    .slot_addr  (slot_addr),
    .slot_valid (slot_valid),
    .slot_x     (slot_x),
    .slot_y     (slot_y),
    .kill_req   (kill_req),
    .kill_addr  (kill_addr),
    .kill_ack   (kill_ack),
    .duck_hit   (duck_hit),
    .hit_count  (hit_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // slot table: registered read, one cycle after the address
  always @(posedge clk) begin
    slot_valid <= (tv[slot_addr] != 0);
    slot_x     <= 10'(tx[slot_addr]);
    slot_y     <= 10'(ty[slot_addr]);
  end

  // kill responder: kill_req stays up ack_hold+1 cycles including the ack cycle
  always @(posedge clk) begin
    if (kill_req && !kill_ack_r) begin
      ack_cnt <= ack_cnt + 1;
      if (ack_cnt + 1 >= ack_hold) kill_ack_r <= 1'b1;
    end else begin
      ack_cnt    <= 0;
      kill_ack_r <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input int i);
    return (tv[i] != 0) && (tx[i] >= dk_x) && (tx[i] <= dk_x + DUCK_W - 1)
        && (ty[i] >= dk_y) && (ty[i] <= dk_y + DUCK_H - 1);
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic set_duck(input int x, input int y);
    dk_x   = x;
    dk_y   = y;
    duck_x = 10'(x);
    duck_y = 10'(y);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 8; i++) begin
      tv[i] = 0;
      tx[i] = 0;
      ty[i] = 0;
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y);
    tv[i] = 1;
    tx[i] = x;
    ty[i] = y;
  endtask

  // One frame: model predicts the first hit slot, scan length and kill window
  task automatic run_frame(input int abort_k, input bit overrun);
    int  h, s, len, kq_lo, kq_hi, exp_sa;
    bit  killed, in_kq;
    h = -1;
    for (int i = 0; i < 8; i++) if (h < 0 && model_hit(i)) h = i;
    if (abort_k >= 0 && (h < 0 || abort_k <= h)) begin
      killed = 0; s = abort_k; len = 2 * s + 3;
    end else if (h >= 0) begin
      killed = 1; s = h; len = 2 * h + ack_hold + 4;
    end else begin
      killed = 0; s = 7; len = 17;
    end
    kq_lo = 2 * h + 3;
    kq_hi = 2 * h + 3 + ack_hold;
    duck_alive = 1'b1;
    @(negedge clk);
    frame_tick = 1'b1;
    for (int c = 1; c <= len + 2; c++) begin
      @(negedge clk);
      frame_tick     = overrun && (c == 3);
      kill_ack_stray = !killed && (c == 4);
      if (abort_k >= 0 && c == 2 * abort_k + 2) duck_alive = 1'b0;
      exp_sa = ((c - 1) / 2 > s) ? s : (c - 1) / 2;
      in_kq  = killed && c >= kq_lo && c <= kq_hi;
      check_eq("busy", int'(busy), int'(c <= len));
      check_eq("slot_addr", int'(slot_addr), exp_sa);
      check_eq("kill_req", int'(kill_req), int'(in_kq));
      if (in_kq) check_eq("kill_addr", int'(kill_addr), h);
      check_eq("duck_hit", int'(duck_hit), int'(killed && c == len));
    end
    frame_tick     = 1'b0;
    kill_ack_stray = 1'b0;
    duck_alive     = 1'b1;
    if (killed) begin
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      tv[h]   = 0;
    end
    last_s = s;
    check_eq("hit_count", int'(hit_count), exp_cnt);
  endtask

  task automatic rand_frame();
    int dx, dy, ab;
    dx = int'($urandom_range(0, 1023));
    dy = int'($urandom_range(0, 1023)) - 512;
    set_duck(dx, dy);
    for (int i = 0; i < 8; i++) begin
      tv[i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      tx[i] = clamp(dx - 4 + int'($urandom_range(0, DUCK_W + 8)), 0, 1023);
      ty[i] = clamp(dy - 4 + int'($urandom_range(0, DUCK_H + 8)), -512, 511);
    end
    ack_hold = int'($urandom_range(1, 4));
    ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
    run_frame(ab, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    reset          = 1'b0;
    frame_tick     = 1'b0;
    duck_alive     = 1'b1;
    kill_ack_stray = 1'b0;
    ack_hold       = 1;
    exp_cnt        = 0;
    last_s         = 0;
    clear_slots();
    set_duck(100, 50);
    #2;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_kill_req", int'(kill_req), 0);
    check_eq("rst_kill_addr", int'(kill_addr), 0);
    check_eq("rst_slot_addr", int'(slot_addr), 0);
    check_eq("rst_duck_hit", int'(duck_hit), 0);
    check_eq("rst_hit_count", int'(hit_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // frame_tick with a dead duck is ignored
    duck_alive = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("dead_busy", int'(busy), 0);
      check_eq("dead_slot_addr", int'(slot_addr), last_s);
      @(negedge clk);
    end
    duck_alive = 1'b1;

    // full miss scan with an overrun tick mid-scan
    clear_slots();
    run_frame(-1, 1'b1);

    // single hit on slot 3 with delayed ack
    set_slot(3, 110, 60);
    ack_hold = 3;
    run_frame(-1, 1'b0);

    // box edges, signed y and right-edge headroom near x=1023
    ack_hold = 1;
    clear_slots(); set_slot(0, 131, 81); run_frame(-1, 1'b0);
    clear_slots(); set_slot(0, 132, 81); run_frame(-1, 1'b0);
    clear_slots(); set_slot(0, 99, 50);  run_frame(-1, 1'b0);
    clear_slots(); set_duck(100, -20); set_slot(2, 110, -5); run_frame(-1, 1'b0);
    clear_slots(); set_duck(1010, 0); set_slot(1, 1020, 31); run_frame(-1, 1'b0);

    // abort during slot 2 check, hit pending at slot 5
    clear_slots(); set_duck(100, 50); set_slot(5, 100, 50);
    run_frame(2, 1'b0);

    for (int f = 0; f < 40; f++) rand_frame();

    // saturation
    clear_slots(); set_duck(200, 100);
    ack_hold = 1;
    for (int f = 0; f < 260; f++) begin
      set_slot(0, 215, 115);
      run_frame(-1, 1'b0);
    end
    check_eq("sat_hit_count", int'(hit_count), 255);

    // reset while kill_req is up
    clear_slots(); set_duck(100, 50); set_slot(0, 110, 60);
    ack_hold = 10;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_kill_req", int'(kill_req), 1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_kill_req", int'(kill_req), 0);
    check_eq("async_hit_count", int'(hit_count), 0);
    check_eq("async_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    exp_cnt  = 0;
    last_s   = 0;
    ack_hold = 2;
    run_frame(-1, 1'b0);
    for (int f = 0; f < 5; f++) rand_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
